// File: rtl/sd_emmc_controller_m_axi_wr.sv
// Single-beat AXI4 write engine: one 32-bit word per request, completion pulse only after B response.
// Optional macro SD_EMMC_AXI_BRESP_CHECK_EN: SLVERR/DECERR responses also set the sticky wr_error flag.
module sd_emmc_controller_m_axi_wr #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              next_data_word,
    output logic              busy,
    output logic              wr_error,
    input  logic              err_clear,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state_q;
    logic [ADDR_W-1:0]      awaddr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   bready_q;
    logic                   next_data_word_q;
    logic                   busy_q;
    logic                   wr_error_q;
    logic                   aw_done_q;
    logic                   w_done_q;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q;

    logic                   aw_fire;
    logic                   w_fire;
    logic                   aw_done_d;
    logic                   w_done_d;
    logic                   tmo_hit;
    logic                   bresp_err;
    logic                   err_set;
    logic [TIMEOUT_W-1:0]   tmo_cnt_d;

    assign aw_fire   = awvalid_q & m_axi_awready;
    assign w_fire    = wvalid_q & m_axi_wready;
    assign aw_done_d = aw_done_q | aw_fire;
    assign w_done_d  = w_done_q | w_fire;
    assign tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    assign tmo_hit   = ((state_q == ADDR_DATA) || (state_q == RESP)) && (tmo_cnt_q == '1);

`ifdef SD_EMMC_AXI_BRESP_CHECK_EN
    // bresp[1] covers both SLVERR (2'b10) and DECERR (2'b11)
    assign bresp_err = m_axi_bresp[1];
`else
    logic unused_bresp;
    assign unused_bresp = ^m_axi_bresp;
    assign bresp_err    = 1'b0;
`endif

    assign err_set = tmo_hit | ((state_q == RESP) & m_axi_bvalid & bresp_err);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            awaddr_q         <= '0;
            wdata_q          <= '0;
            awvalid_q        <= 1'b0;
            wvalid_q         <= 1'b0;
            bready_q         <= 1'b0;
            next_data_word_q <= 1'b0;
            busy_q           <= 1'b0;
            wr_error_q       <= 1'b0;
            aw_done_q        <= 1'b0;
            w_done_q         <= 1'b0;
            tmo_cnt_q        <= '0;
        end else begin
            next_data_word_q <= 1'b0;

            // A set event in the same cycle as err_clear keeps the flag raised
            if (err_set) begin
                wr_error_q <= 1'b1;
            end else if (err_clear) begin
                wr_error_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    tmo_cnt_q <= '0;
                    if (req_valid) begin
                        awaddr_q  <= req_addr;
                        wdata_q   <= req_data;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done_d && w_done_d) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q         <= 1'b0;
                        next_data_word_q <= 1'b1;
                        tmo_cnt_q        <= '0;
                        state_q          <= DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                DONE: begin
                    busy_q    <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    tmo_cnt_q <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign next_data_word = next_data_word_q;
    assign busy           = busy_q;
    assign wr_error       = wr_error_q;
    assign m_axi_awaddr   = awaddr_q;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = 3'b010;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awcache  = 4'b0011;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = 4'hF;
    assign m_axi_wlast    = wvalid_q;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_bready   = bready_q;

endmodule
